// File: rtl/strobe_period_monitor.sv
// Checks a single-cycle rate strobe against its nominal period in clk cycles.
// Reports lock, flags early/late strobes, counts errors and keeps the last interval.
module strobe_period_monitor #(
    parameter int PERIOD     = 1000,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_in,
    input  logic             clear_errors,
    output logic             locked,
    output logic             period_ok,
    output logic             err_early,
    output logic             err_late,
    output logic [15:0]      err_count,
    output logic [CNT_W-1:0] last_period
);

    localparam int GOOD_W      = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int EARLY_BELOW = (TOLERANCE >= PERIOD) ? 0 : PERIOD - TOLERANCE;
    localparam logic [CNT_W-1:0]  LATE_CNT  = CNT_W'(PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0]  EARLY_CNT = CNT_W'(EARLY_BELOW);
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] goodCnt_q;
    logic [15:0]       errCount_q, errCount_d;
    logic [CNT_W-1:0]  lastPeriod_q;
    logic              locked_q, periodOk_q, errEarly_q, errLate_q;
    logic              active, lateHit, earlyHit, goodHit;

    // cnt_q holds the cycles elapsed since the reference strobe, so at the next
    // strobe it is the interval; a strobe on the late cycle still counts as good.
    always_comb begin
        active     = (state_q != IDLE);
        lateHit    = active && !strobe_in && (cnt_q == LATE_CNT);
        earlyHit   = active && strobe_in && (cnt_q < EARLY_CNT);
        goodHit    = active && strobe_in && !earlyHit;

        cnt_d = cnt_q + 1'b1;
        if (strobe_in) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!active || lateHit) begin
            cnt_d = '0;
        end

        errCount_d = errCount_q;
        if (clear_errors) begin
            errCount_d = '0;
        end else if ((lateHit || earlyHit) && (errCount_q != 16'hFFFF)) begin
            errCount_d = errCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            goodCnt_q    <= '0;
            errCount_q   <= '0;
            lastPeriod_q <= '0;
            locked_q     <= 1'b0;
            periodOk_q   <= 1'b0;
            errEarly_q   <= 1'b0;
            errLate_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            errCount_q <= errCount_d;
            periodOk_q <= goodHit;
            errEarly_q <= earlyHit;
            errLate_q  <= lateHit;
            if (active && strobe_in) begin
                lastPeriod_q <= cnt_q;
            end

            case (state_q)
                IDLE: begin
                    locked_q <= 1'b0;
                    if (strobe_in) begin
                        state_q   <= ACQUIRE;
                        goodCnt_q <= '0;
                    end
                end
                ACQUIRE: begin
                    if (lateHit) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end else if (earlyHit) begin
                        goodCnt_q <= '0;
                    end else if (goodHit) begin
                        if (goodCnt_q == LOCK_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            goodCnt_q <= goodCnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (lateHit) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end else if (earlyHit) begin
                        state_q   <= ACQUIRE;
                        goodCnt_q <= '0;
                        locked_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked      = locked_q;
    assign period_ok   = periodOk_q;
    assign err_early   = errEarly_q;
    assign err_late    = errLate_q;
    assign err_count   = errCount_q;
    assign last_period = lastPeriod_q;

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Scoreboard bench: two monitors (TOLERANCE 0 and 1, PERIOD 10) driven by
// directed and random strobes, compared every cycle against a timestamp model.
module tb_strobe_period_monitor;

    localparam int P = 10;
    localparam int L = 4;

    typedef struct packed {
        logic        ok;
        logic        early;
        logic        late;
        logic        lck;
        logic [15:0] errs;
        logic [15:0] last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  strobe = '0;
    logic [1:0]  clr = '0;
    logic [1:0]  lockedW, okW, earlyW, lateW;
    logic [15:0] errW [2];
    logic [15:0] lastW [2];

    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    int tol [2] = '{0, 1};
    int hasRef [2], elapsed [2], goodRun [2], mLocked [2], mErrs [2], mLast [2];
    int cd [2];

    always #5 clk = ~clk;

    strobe_period_monitor #(.PERIOD(P), .TOLERANCE(0), .LOCK_COUNT(L), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .strobe_in(strobe[0]), .clear_errors(clr[0]),
        .locked(lockedW[0]), .period_ok(okW[0]), .err_early(earlyW[0]), .err_late(lateW[0]),
        .err_count(errW[0]), .last_period(lastW[0]));

    strobe_period_monitor #(.PERIOD(P), .TOLERANCE(1), .LOCK_COUNT(L), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .strobe_in(strobe[1]), .clear_errors(clr[1]),
        .locked(lockedW[1]), .period_ok(okW[1]), .err_early(earlyW[1]), .err_late(lateW[1]),
        .err_count(errW[1]), .last_period(lastW[1]));

    function automatic exp_t actual(input int i);
        exp_t a;
        a.ok    = okW[i];
        a.early = earlyW[i];
        a.late  = lateW[i];
        a.lck   = lockedW[i];
        a.errs  = errW[i];
        a.last  = lastW[i];
        return a;
    endfunction

    task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s t=%0t got ok=%b early=%b late=%b lock=%b errs=%0d last=%0d want ok=%b early=%b late=%b lock=%b errs=%0d last=%0d",
                     name, $time, act.ok, act.early, act.late, act.lck, act.errs, act.last,
                     exp.ok, exp.early, exp.late, exp.lck, exp.errs, exp.last);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            hasRef[i] = 0; elapsed[i] = 0; goodRun[i] = 0;
            mLocked[i] = 0; mErrs[i] = 0; mLast[i] = 0;
        end
    endtask

    // Reference rules: interval = cycles since the last reference strobe.
    function automatic exp_t modelStep(input int i, input bit s, input bit c);
        exp_t e;
        int k;
        bit err;
        e = '0;
        err = 0;
        if (hasRef[i] == 0) begin
            if (s) begin
                hasRef[i] = 1; elapsed[i] = 0; goodRun[i] = 0;
            end
        end else begin
            k = elapsed[i] + 1;
            if (s) begin
                mLast[i] = k;
                elapsed[i] = 0;
                if (k >= P - tol[i] && k <= P + tol[i]) begin
                    e.ok = 1;
                    goodRun[i]++;
                    if (goodRun[i] >= L) mLocked[i] = 1;
                end else begin
                    e.early = 1; err = 1;
                    goodRun[i] = 0; mLocked[i] = 0;
                end
            end else if (k == P + tol[i]) begin
                e.late = 1; err = 1;
                hasRef[i] = 0; mLocked[i] = 0; elapsed[i] = 0;
            end else begin
                elapsed[i] = k;
            end
        end
        if (c) mErrs[i] = 0;
        else if (err && mErrs[i] < 65535) mErrs[i]++;
        e.lck  = mLocked[i][0];
        e.errs = 16'(mErrs[i]);
        e.last = 16'(mLast[i]);
        return e;
    endfunction

    task automatic applyStimulus(input bit s0, input bit c0, input bit s1, input bit c1);
        @(negedge clk);
        strobe[0] = s0; clr[0] = c0;
        strobe[1] = s1; clr[1] = c1;
        q0.push_back(modelStep(0, s0, c0));
        q1.push_back(modelStep(1, s1, c1));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(0, 0, 0, 0);
    endtask

    // Strobe interval k on both instances (k-1 quiet cycles then a strobe).
    task automatic strobeAfter(input int k0, input int k1);
        int n;
        n = (k0 > k1) ? k0 : k1;
        for (int j = 1; j <= n; j++) begin
            applyStimulus(j == k0, 0, j == k1, 0);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q0.size() > 0) checkOutput("dut0", actual(0), q0.pop_front());
        if (q1.size() > 0) checkOutput("dut1", actual(1), q1.pop_front());
    end

    initial begin
        exp_t zero;
        zero = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset0", actual(0), zero);
        checkOutput("reset1", actual(1), zero);
        rst = 1'b0;

        applyStimulus(1, 0, 1, 0);
        for (int j = 0; j < 6; j++) strobeAfter(10, 10);
        strobeAfter(9, 9);
        for (int j = 0; j < 5; j++) strobeAfter(10, 10);
        idle(15);
        applyStimulus(1, 0, 1, 0);
        strobeAfter(9, 9);
        strobeAfter(11, 11);
        strobeAfter(10, 10);
        strobeAfter(11, 11);
        strobeAfter(10, 12);
        strobeAfter(10, 10);
        strobeAfter(10, 8);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 0);

        cd[0] = 3; cd[1] = 5;
        for (int n = 0; n < 4000; n++) begin
            bit s [2];
            bit c [2];
            for (int i = 0; i < 2; i++) begin
                s[i] = (cd[i] == 0) || ($urandom_range(0, 49) == 0);
                c[i] = ($urandom_range(0, 63) == 0);
                if (cd[i] == 0) cd[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 13) : 9;
                else cd[i]--;
            end
            applyStimulus(s[0], c[0], s[1], c[1]);
        end

        for (int j = 0; j < 6; j++) strobeAfter(10, 10);
        idle(4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async0", actual(0), zero);
        checkOutput("async1", actual(1), zero);
        modelReset();
        q0.delete();
        q1.delete();
        rst = 1'b0;

        for (int j = 0; j < 65541; j++) applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 1);
        strobeAfter(10, 10);
        strobeAfter(10, 10);
        applyStimulus(0, 0, 0, 0);

        @(posedge clk);
        #3;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
